// File: rtl/resource_lock_client_pkg.sv
// Shared types and helpers for the resource lock client and its pool.
package resource_lock_client_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } lock_client_state_e;

  localparam int LOCK_ID_WIDTH = 8;

  // Wrap-around ordering: a is older than b when the MSB of (a - b) is set.
  function automatic logic is_seq_smaller(input logic [LOCK_ID_WIDTH-1:0] a,
                                          input logic [LOCK_ID_WIDTH-1:0] b);
    logic [LOCK_ID_WIDTH-1:0] diff;
    diff = a - b;
    return diff[LOCK_ID_WIDTH-1];
  endfunction

endpackage

// File: rtl/resource_lock_client_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {WIDTH{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/resource_lock_client.sv
// Requester-side client of the resource pool: takes one op, requests a resource,
// holds it while the execution unit uses it, and releases it on done/flush/timeout.
module resource_lock_client
  import resource_lock_client_pkg::*;
#(
  parameter int ID_WIDTH       = 8,
  parameter int RES_ID_WIDTH   = 2,
  parameter int MAX_HOLD       = 255,
  parameter int WAIT_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [ID_WIDTH-1:0]       op_issue_id,
  input  logic                      flush,
  output logic                      req,
  output logic [ID_WIDTH-1:0]       req_issue_id,
  output logic                      release_lock,
  input  logic                      grant,
  input  logic [RES_ID_WIDTH-1:0]   alloc_id,
  output logic                      use_valid,
  output logic [RES_ID_WIDTH-1:0]   use_res_id,
  output logic [ID_WIDTH-1:0]       use_issue_id,
  input  logic                      use_done,
  output logic [WAIT_CNT_WIDTH-1:0] last_wait,
  output logic                      err_timeout,
  output logic                      err_lost,
  output lock_client_state_e        dbg_state
);

  localparam int HOLD_W    = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);
  localparam int HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  lock_client_state_e        state;
  logic [ID_WIDTH-1:0]       id_q;
  logic [RES_ID_WIDTH-1:0]   res_q;
  logic [HOLD_W-1:0]         hold_cnt;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
  logic                      timeout;
  logic                      rel_cond;

  // Op handshake: an op transfers on a cycle where op_valid && op_ready;
  // op_ready is high only in IDLE, so at most one op is in flight.
  assign op_ready     = (state == IDLE);
  assign req          = ((state == REQ) && !flush) || (state == HOLD);
  assign req_issue_id = id_q;
  assign use_valid    = (state == HOLD);
  assign use_res_id   = res_q;
  assign use_issue_id = id_q;
  assign dbg_state    = state;

  assign timeout      = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(HOLD_LAST));
  assign rel_cond     = flush || use_done || timeout;
  // A dropped grant means the pool no longer records us as owner, so no release.
  assign release_lock = (state == HOLD) && grant && rel_cond;

  sat_counter #(.WIDTH(WAIT_CNT_WIDTH)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state == IDLE) && op_valid),
    .inc   ((state == REQ) && !flush && !grant),
    .q     (wait_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      id_q        <= '0;
      res_q       <= '0;
      hold_cnt    <= '0;
      last_wait   <= '0;
      err_timeout <= 1'b0;
      err_lost    <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      err_lost    <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid) begin
            id_q  <= op_issue_id;
            state <= REQ;
          end
        end
        REQ: begin
          if (flush) begin
            state <= IDLE;
          end else if (grant) begin
            res_q     <= alloc_id;
            last_wait <= wait_cnt;
            hold_cnt  <= '0;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (!grant) begin
            err_lost <= 1'b1;
            state    <= IDLE;
          end else if (rel_cond) begin
            err_timeout <= timeout && !flush && !use_done;
            state       <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_resource_lock_client.sv
// Directed bench for resource_lock_client with an occupancy model checked every cycle.
module tb_resource_lock_client;
  import resource_lock_client_pkg::*;

  localparam int IDW   = 8;
  localparam int RESW  = 2;
  localparam int MAXH  = 8;
  localparam int WCW   = 4;
  localparam int WSAT  = (1 << WCW) - 1;

  logic            clk;
  logic            rst_n;
  logic            op_valid;
  logic            op_ready;
  logic [IDW-1:0]  op_issue_id;
  logic            flush;
  logic            req;
  logic [IDW-1:0]  req_issue_id;
  logic            release_lock;
  logic            grant;
  logic [RESW-1:0] alloc_id;
  logic            use_valid;
  logic [RESW-1:0] use_res_id;
  logic [IDW-1:0]  use_issue_id;
  logic            use_done;
  logic [WCW-1:0]  last_wait;
  logic            err_timeout;
  logic            err_lost;
  logic [1:0]      dbg_state;

  int checks = 0;
  int errors = 0;

  resource_lock_client #(
    .ID_WIDTH(IDW), .RES_ID_WIDTH(RESW), .MAX_HOLD(MAXH), .WAIT_CNT_WIDTH(WCW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_issue_id(op_issue_id), .flush(flush), .req(req), .req_issue_id(req_issue_id),
    .release_lock(release_lock), .grant(grant), .alloc_id(alloc_id),
    .use_valid(use_valid), .use_res_id(use_res_id), .use_issue_id(use_issue_id),
    .use_done(use_done), .last_wait(last_wait), .err_timeout(err_timeout),
    .err_lost(err_lost), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the client is either free (0), waiting for a resource (1) or owning one (2).
  int m_kind, m_wait, m_hold, m_last_wait;
  logic [IDW-1:0]  m_id;
  logic [RESW-1:0] m_res;
  logic m_err_to, m_err_lost;
  int n_kind, n_wait, n_hold, n_last_wait;
  logic [IDW-1:0]  n_id;
  logic [RESW-1:0] n_res;
  logic n_err_to, n_err_lost;

  always @(negedge clk) begin
    logic e_req, e_rel, tmo;
    tmo   = (m_kind == 2) && (m_hold == MAXH - 1);
    e_req = ((m_kind == 1) && !flush) || (m_kind == 2);
    e_rel = (m_kind == 2) && grant && (flush || use_done || tmo);
    chk("op_ready", op_ready, m_kind == 0);
    chk("req", req, e_req);
    chk("release_lock", release_lock, e_rel);
    chk("use_valid", use_valid, m_kind == 2);
    if (m_kind == 2) begin
      chk("use_res_id", use_res_id, m_res);
      chk("use_issue_id", use_issue_id, m_id);
    end
    if (e_req) chk("req_issue_id", req_issue_id, m_id);
    chk("last_wait", last_wait, m_last_wait);
    chk("err_timeout", err_timeout, m_err_to);
    chk("err_lost", err_lost, m_err_lost);

    n_kind = m_kind; n_wait = m_wait; n_hold = m_hold; n_last_wait = m_last_wait;
    n_id = m_id; n_res = m_res; n_err_to = 1'b0; n_err_lost = 1'b0;
    if (!rst_n) begin
      n_kind = 0; n_wait = 0; n_hold = 0; n_last_wait = 0; n_id = '0; n_res = '0;
    end else if (m_kind == 0) begin
      if (op_valid) begin n_kind = 1; n_id = op_issue_id; n_wait = 0; end
    end else if (m_kind == 1) begin
      if (flush) n_kind = 0;
      else if (grant) begin
        n_kind = 2; n_res = alloc_id; n_last_wait = m_wait; n_hold = 0;
      end else if (m_wait < WSAT) n_wait = m_wait + 1;
    end else begin
      if (!grant) begin n_kind = 0; n_err_lost = 1'b1; end
      else if (e_rel) begin n_kind = 0; n_err_to = tmo && !flush && !use_done; end
      else n_hold = m_hold + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_kind = 0; m_wait = 0; m_hold = 0; m_last_wait = 0;
      m_id = '0; m_res = '0; m_err_to = 1'b0; m_err_lost = 1'b0;
    end else begin
      m_kind = n_kind; m_wait = n_wait; m_hold = n_hold; m_last_wait = n_last_wait;
      m_id = n_id; m_res = n_res; m_err_to = n_err_to; m_err_lost = n_err_lost;
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [IDW-1:0] id);
    op_valid = 1'b1; op_issue_id = id;
    cyc();
    op_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; op_issue_id = '0; flush = 1'b0;
    grant = 1'b0; alloc_id = '0; use_done = 1'b0;
    cyc(); cyc();
    chk("rst_op_ready", op_ready, 1); chk("rst_req", req, 0);
    chk("rst_use_valid", use_valid, 0); chk("rst_last_wait", last_wait, 0);
    chk("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;
    cyc();

    // basic: granted in the first REQ cycle, done in the third HOLD cycle
    offer(8'd5);
    grant = 1'b1; alloc_id = 2'd0; #1;
    chk("basic_req", req, 1); chk("basic_req_id", req_issue_id, 5);
    cyc();
    chk("basic_last_wait", last_wait, 0); chk("basic_res", use_res_id, 0);
    chk("basic_use_valid", use_valid, 1);
    cyc(); cyc();
    use_done = 1'b1; #1;
    chk("basic_release", release_lock, 1);
    cyc();
    use_done = 1'b0; grant = 1'b0; #1;
    chk("basic_ready_after", op_ready, 1);

    // contention wait: four denied REQ cycles before the grant
    offer(8'd10);
    repeat (4) cyc();
    grant = 1'b1; alloc_id = 2'd1;
    cyc();
    chk("wait_last_wait", last_wait, 4); chk("wait_res", use_res_id, 1);
    use_done = 1'b1;
    cyc();
    use_done = 1'b0; grant = 1'b0;

    // long wait saturates the counter, then flush releases without error
    offer(8'd20);
    repeat (20) cyc();
    grant = 1'b1; alloc_id = 2'd2;
    cyc();
    chk("sat_last_wait", last_wait, WSAT);
    flush = 1'b1; #1;
    chk("hold_flush_release", release_lock, 1);
    cyc();
    flush = 1'b0; grant = 1'b0; #1;
    chk("hold_flush_no_to", err_timeout, 0); chk("hold_flush_no_lost", err_lost, 0);

    // flush while requesting: request drops in the same cycle
    offer(8'd30);
    cyc();
    flush = 1'b1; #1;
    chk("req_flush_req_low", req, 0); chk("req_flush_no_rel", release_lock, 0);
    cyc();
    flush = 1'b0; #1;
    chk("req_flush_idle", op_ready, 1); chk("req_flush_no_use", use_valid, 0);

    // hold timeout on the eighth HOLD cycle
    offer(8'd40);
    grant = 1'b1; alloc_id = 2'd3;
    cyc();
    repeat (7) cyc();
    chk("timeout_release", release_lock, 1);
    cyc();
    grant = 1'b0; #1;
    chk("timeout_err", err_timeout, 1); chk("timeout_ready", op_ready, 1);

    // same resource granted again, then the grant is lost
    offer(8'd50);
    grant = 1'b1; alloc_id = 2'd3;
    cyc();
    chk("regrant_res", use_res_id, 3);
    cyc();
    grant = 1'b0; #1;
    chk("lost_no_release", release_lock, 0);
    cyc();
    chk("lost_err", err_lost, 1); chk("lost_no_to", err_timeout, 0);

    // reset while holding
    offer(8'd60);
    grant = 1'b1; alloc_id = 2'd2;
    cyc(); cyc();
    rst_n = 1'b0; #1;
    chk("midrst_use_valid", use_valid, 0); chk("midrst_op_ready", op_ready, 1);
    chk("midrst_req", req, 0);
    cyc();
    rst_n = 1'b1; grant = 1'b0;
    cyc();

    // flush in IDLE does not block acceptance
    flush = 1'b1; op_valid = 1'b1; op_issue_id = 8'd70; #1;
    chk("idle_flush_ready", op_ready, 1);
    cyc();
    flush = 1'b0; op_valid = 1'b0; #1;
    chk("idle_flush_req", req, 1); chk("idle_flush_req_id", req_issue_id, 70);
    flush = 1'b1;
    cyc();
    flush = 1'b0;

    // wrap-around ordering helper
    chk("seq_fe_01", is_seq_smaller(8'hFE, 8'h01), 1);
    chk("seq_01_fe", is_seq_smaller(8'h01, 8'hFE), 0);
    chk("seq_10_11", is_seq_smaller(8'd10, 8'd11), 1);

    repeat (3) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
